// File: rtl/clock_ctrl_pkg.sv
// Shared constants for the clock set controller: FSM state encoding, field widths and limits.
// Also provides wrap-around increment and range-clamp helpers for the hours/minutes fields.
// Imported by the controller interface, the controller top and the bench.
package clock_ctrl_pkg;

    localparam int HRS_W = 5;
    localparam int MIN_W = 6;

    localparam logic [HRS_W-1:0] MAX_HRS = HRS_W'(23);
    localparam logic [MIN_W-1:0] MAX_MIN = MIN_W'(59);

    // Encoding is exported on mode_o for display blanking, so values are fixed.
    typedef enum logic [2:0] {
        RUN        = 3'd0,
        SET_HRS    = 3'd1,
        SET_MIN    = 3'd2,
        SET_AL_HRS = 3'd3,
        SET_AL_MIN = 3'd4,
        COMMIT     = 3'd5
    } state_t;

    // Compare before adding so an out-of-range value can never be produced.
    function automatic logic [HRS_W-1:0] inc_hrs(input logic [HRS_W-1:0] v);
        return (v >= MAX_HRS) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] v);
        return (v >= MAX_MIN) ? '0 : v + 1'b1;
    endfunction

    // Live counter values are trusted but clamped so a glitch can never be reloaded.
    function automatic logic [HRS_W-1:0] clamp_hrs(input logic [HRS_W-1:0] v);
        return (v > MAX_HRS) ? '0 : v;
    endfunction

    function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] v);
        return (v > MAX_MIN) ? '0 : v;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bundle of front-panel buttons, live time, and controller outputs for clock_set_ctrl.
// Names carry the controller's direction: _i driven into the controller, _o driven by it.
// Modports: slave = controller side, master = buttons/counter side.
interface clock_set_ctrl_if;
    import clock_ctrl_pkg::*;

    logic             btn_mode_i;   // single-cycle pulse: advance edit state
    logic             btn_inc_i;    // single-cycle pulse: increment field / dismiss alarm
    logic [HRS_W-1:0] cur_hrs_i;    // live hours from counter
    logic [MIN_W-1:0] cur_min_i;    // live minutes from counter
    logic             tick_o;       // one-cycle counter-advance strobe
    logic             load_o;       // one-cycle parallel-load strobe
    logic [HRS_W-1:0] load_hrs_o;
    logic [MIN_W-1:0] load_min_o;
    logic [MIN_W-1:0] load_sec_o;
    logic [HRS_W-1:0] edit_hrs_o;   // shadow hours for display during set
    logic [MIN_W-1:0] edit_min_o;   // shadow minutes for display during set
    logic [2:0]       mode_o;       // FSM state encoding
    logic             alarm_o;      // alarm active (level)

    modport slave (
        input  btn_mode_i, btn_inc_i, cur_hrs_i, cur_min_i,
        output tick_o, load_o, load_hrs_o, load_min_o, load_sec_o,
               edit_hrs_o, edit_min_o, mode_o, alarm_o
    );

    modport master (
        output btn_mode_i, btn_inc_i, cur_hrs_i, cur_min_i,
        input  tick_o, load_o, load_hrs_o, load_min_o, load_sec_o,
               edit_hrs_o, edit_min_o, mode_o, alarm_o
    );

endinterface

// File: rtl/clock_set_ctrl_tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV into a one-cycle tick while en is high.
// Latency: tick registered, high the cycle after the count reaches TICK_DIV-1.
// No backpressure; en low holds the count at 0 and suppresses tick.
// Ports: clk, rst (sync, active-high), en (count enable), tick (registered strobe).
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: tick generation plus two-button time-set FSM with one-cycle load to the counter.
// Latency: all outputs registered; load appears in the COMMIT cycle, one edge after the last btn_mode.
// No backpressure; buttons are single-cycle pulses, ignored in COMMIT; mode wins over inc.
// Ports: clk, rst (sync, active-high), bus (clock_set_ctrl_if.slave: buttons, live time, outputs).
// Build option: define CLOCK_ALARM_EN to add alarm set states, alarm registers and the alarm output.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic              clk,
    input  logic              rst,
    clock_set_ctrl_if.slave   bus
);

    state_t           state_q, state_d;
    logic [HRS_W-1:0] edit_hrs_q, edit_hrs_d;
    logic [MIN_W-1:0] edit_min_q, edit_min_d;
    logic             load_q, load_d;
    logic [HRS_W-1:0] load_hrs_q, load_hrs_d;
    logic [MIN_W-1:0] load_min_q, load_min_d;
    logic             tick;

`ifdef CLOCK_ALARM_EN
    logic [HRS_W-1:0] al_hrs_q, al_hrs_d;
    logic [MIN_W-1:0] al_min_q, al_min_d;
    logic             armed_q, armed_d;
    logic             alarm_q, alarm_d;
`endif

    // Enable from next state so the prescaler restarts on the COMMIT->RUN edge,
    // putting the first tick exactly TICK_DIV cycles after load.
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (state_d == RUN),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            edit_hrs_q <= '0;
            edit_min_q <= '0;
            load_q     <= 1'b0;
            load_hrs_q <= '0;
            load_min_q <= '0;
`ifdef CLOCK_ALARM_EN
            al_hrs_q   <= '0;
            al_min_q   <= '0;
            armed_q    <= 1'b0;
            alarm_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            edit_hrs_q <= edit_hrs_d;
            edit_min_q <= edit_min_d;
            load_q     <= load_d;
            load_hrs_q <= load_hrs_d;
            load_min_q <= load_min_d;
`ifdef CLOCK_ALARM_EN
            al_hrs_q   <= al_hrs_d;
            al_min_q   <= al_min_d;
            armed_q    <= armed_d;
            alarm_q    <= alarm_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        edit_hrs_d = edit_hrs_q;
        edit_min_d = edit_min_q;
        load_d     = 1'b0;
        load_hrs_d = load_hrs_q;
        load_min_d = load_min_q;
`ifdef CLOCK_ALARM_EN
        al_hrs_d   = al_hrs_q;
        al_min_d   = al_min_q;
        armed_d    = armed_q;
        alarm_d    = 1'b0;
`endif

        case (state_q)
            RUN: begin
                if (bus.btn_mode_i) begin
                    state_d    = SET_HRS;
                    edit_hrs_d = clamp_hrs(bus.cur_hrs_i);
                    edit_min_d = clamp_min(bus.cur_min_i);
                end
`ifdef CLOCK_ALARM_EN
                else if (bus.btn_inc_i) begin
                    armed_d = 1'b0;
                end
`endif
            end
            SET_HRS: begin
                if (bus.btn_mode_i)     state_d    = SET_MIN;
                else if (bus.btn_inc_i) edit_hrs_d = inc_hrs(edit_hrs_q);
            end
            SET_MIN: begin
`ifdef CLOCK_ALARM_EN
                if (bus.btn_mode_i)     state_d    = SET_AL_HRS;
`else
                if (bus.btn_mode_i)     state_d    = COMMIT;
`endif
                else if (bus.btn_inc_i) edit_min_d = inc_min(edit_min_q);
            end
`ifdef CLOCK_ALARM_EN
            SET_AL_HRS: begin
                if (bus.btn_mode_i)     state_d  = SET_AL_MIN;
                else if (bus.btn_inc_i) al_hrs_d = inc_hrs(al_hrs_q);
            end
            SET_AL_MIN: begin
                if (bus.btn_mode_i)     state_d  = COMMIT;
                else if (bus.btn_inc_i) al_min_d = inc_min(al_min_q);
            end
`endif
            COMMIT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // COMMIT is only ever entered from a set state, so this fires once per commit.
        if (state_d == COMMIT) begin
            load_d     = 1'b1;
            load_hrs_d = edit_hrs_q;
            load_min_d = edit_min_q;
`ifdef CLOCK_ALARM_EN
            armed_d    = 1'b1;
`endif
        end

`ifdef CLOCK_ALARM_EN
        // Uses next-state armed so a dismiss in RUN drops alarm on the same edge.
        alarm_d = (state_d == RUN) && armed_d &&
                  (bus.cur_hrs_i == al_hrs_q) && (bus.cur_min_i == al_min_q);
`endif
    end

    assign bus.tick_o     = tick;
    assign bus.load_o     = load_q;
    assign bus.load_hrs_o = load_hrs_q;
    assign bus.load_min_o = load_min_q;
    assign bus.load_sec_o = '0;
    assign bus.mode_o     = state_q;

`ifdef CLOCK_ALARM_EN
    // Alarm set states display the alarm registers in place of the time shadow.
    assign bus.edit_hrs_o = (state_q == SET_AL_HRS || state_q == SET_AL_MIN) ? al_hrs_q : edit_hrs_q;
    assign bus.edit_min_o = (state_q == SET_AL_HRS || state_q == SET_AL_MIN) ? al_min_q : edit_min_q;
    assign bus.alarm_o    = alarm_q;
`else
    assign bus.edit_hrs_o = edit_hrs_q;
    assign bus.edit_min_o = edit_min_q;
    assign bus.alarm_o    = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_DIV=100.
// Drives inputs and samples outputs 1ns after each rising edge.
// Alarm scenario is selected by CLOCK_ALARM_EN to match the build under test.
module tb_clock_set_ctrl;
    import clock_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   n_load;
    int   n;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(.TICK_DIV(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.load_o === 1'b1) n_load++;
    endtask

    task automatic press_mode();
        bus.btn_mode_i = 1'b1;
        step();
        bus.btn_mode_i = 1'b0;
    endtask

    task automatic press_inc(input int times);
        for (int i = 0; i < times; i++) begin
            bus.btn_inc_i = 1'b1;
            step();
            bus.btn_inc_i = 1'b0;
        end
    endtask

    // Steps until tick is seen; returns the number of steps (limit if never seen).
    task automatic wait_tick(input int limit, output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (bus.tick_o !== 1'b1 && steps < limit);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        n_load = 0;
        rst = 1'b1;
        bus.btn_mode_i = 1'b0;
        bus.btn_inc_i  = 1'b0;
        bus.cur_hrs_i  = '0;
        bus.cur_min_i  = '0;
        repeat (3) step();

        // 1: reset state, then free-running tick period
        chk("rst_mode", bus.mode_o, 0);
        chk("rst_tick", bus.tick_o, 0);
        chk("rst_load", bus.load_o, 0);
        chk("rst_load_hrs", bus.load_hrs_o, 0);
        chk("rst_edit_hrs", bus.edit_hrs_o, 0);
        chk("rst_edit_min", bus.edit_min_o, 0);
        chk("rst_alarm", bus.alarm_o, 0);
        rst = 1'b0;
        n_load = 0;
        wait_tick(250, n);
        chk("first_tick", n, 100);
        step();
        chk("tick_one_cycle", bus.tick_o, 0);
        wait_tick(250, n);
        chk("tick_period", n, 99);
        wait_tick(250, n);
        chk("tick_period2", n, 100);
        chk("no_load_in_run", n_load, 0);

        // 2: 13:45, hours wrap 23->0, minutes wrap 59->0, load 0:00:00
        bus.cur_hrs_i = 5'd13;
        bus.cur_min_i = 6'd45;
        press_mode();
        chk("t2_mode_sethrs", bus.mode_o, 1);
        chk("t2_cap_hrs", bus.edit_hrs_o, 13);
        chk("t2_cap_min", bus.edit_min_o, 45);
        chk("t2_no_tick_set", bus.tick_o, 0);
        press_inc(10);
        chk("t2_hrs_23", bus.edit_hrs_o, 23);
        press_inc(1);
        chk("t2_hrs_wrap", bus.edit_hrs_o, 0);
        press_mode();
        chk("t2_mode_setmin", bus.mode_o, 2);
        press_inc(14);
        chk("t2_min_59", bus.edit_min_o, 59);
        press_inc(1);
        chk("t2_min_wrap", bus.edit_min_o, 0);
`ifdef CLOCK_ALARM_EN
        press_mode();
        press_mode();
`endif
        n_load = 0;
        press_mode();
        chk("t2_mode_commit", bus.mode_o, 5);
        chk("t2_load", bus.load_o, 1);
        chk("t2_load_hrs", bus.load_hrs_o, 0);
        chk("t2_load_min", bus.load_min_o, 0);
        chk("t2_load_sec", bus.load_sec_o, 0);
        step();
        chk("t2_back_run", bus.mode_o, 0);
        chk("t2_load_drop", bus.load_o, 0);
        wait_tick(250, n);
        chk("t2_tick_after_load", n, 99);
        chk("t2_single_load", n_load, 1);

        // 2b: no-wrap boundary 22:58 -> 23:59, buttons ignored during COMMIT
        bus.cur_hrs_i = 5'd22;
        bus.cur_min_i = 6'd58;
        press_mode();
        press_inc(1);
        press_mode();
        press_inc(1);
`ifdef CLOCK_ALARM_EN
        press_mode();
        press_mode();
`endif
        press_mode();
        chk("t2b_load", bus.load_o, 1);
        chk("t2b_load_hrs", bus.load_hrs_o, 23);
        chk("t2b_load_min", bus.load_min_o, 59);
        bus.btn_mode_i = 1'b1;
        bus.btn_inc_i  = 1'b1;
        step();
        bus.btn_mode_i = 1'b0;
        bus.btn_inc_i  = 1'b0;
        chk("t2b_commit_ignores_btn", bus.mode_o, 0);

        // 3: simultaneous mode+inc in SET_HRS -> SET_MIN, hours unchanged
        bus.cur_hrs_i = 5'd5;
        bus.cur_min_i = 6'd10;
        press_mode();
        bus.btn_mode_i = 1'b1;
        bus.btn_inc_i  = 1'b1;
        step();
        bus.btn_mode_i = 1'b0;
        bus.btn_inc_i  = 1'b0;
        chk("t3_mode_wins", bus.mode_o, 2);
        chk("t3_hrs_kept", bus.edit_hrs_o, 5);
        press_inc(1);
        chk("t3_min_inc", bus.edit_min_o, 11);

        // 4: reset in SET_MIN discards edits, no load
        n_load = 0;
        rst = 1'b1;
        step();
        chk("t4_mode_run", bus.mode_o, 0);
        chk("t4_edit_hrs", bus.edit_hrs_o, 0);
        chk("t4_edit_min", bus.edit_min_o, 0);
        chk("t4_load_hrs", bus.load_hrs_o, 0);
        rst = 1'b0;
        repeat (5) step();
        chk("t4_no_load", n_load, 0);

        // 5/6: alarm sequence at 07:30
        bus.cur_hrs_i = 5'd7;
        bus.cur_min_i = 6'd29;
        press_mode();
        chk("t5_mode1", bus.mode_o, 1);
        press_mode();
        chk("t5_mode2", bus.mode_o, 2);
`ifdef CLOCK_ALARM_EN
        press_mode();
        chk("t5_mode_alhrs", bus.mode_o, 3);
        chk("t5_al_hrs_init", bus.edit_hrs_o, 0);
        press_inc(7);
        chk("t5_al_hrs", bus.edit_hrs_o, 7);
        press_mode();
        chk("t5_mode_almin", bus.mode_o, 4);
        press_inc(30);
        chk("t5_al_min", bus.edit_min_o, 30);
`endif
        press_mode();
        chk("t5_commit", bus.mode_o, 5);
        chk("t5_alarm_commit", bus.alarm_o, 0);
        step();
        chk("t5_run", bus.mode_o, 0);
        step();
        chk("t5_alarm_early", bus.alarm_o, 0);
        bus.cur_min_i = 6'd30;
        step();
`ifdef CLOCK_ALARM_EN
        chk("t5_alarm_on", bus.alarm_o, 1);
        step();
        chk("t5_alarm_held", bus.alarm_o, 1);
`else
        chk("t6_alarm_off", bus.alarm_o, 0);
`endif
        press_inc(1);
        chk("t5_alarm_dismiss", bus.alarm_o, 0);
        chk("t5_inc_run_mode", bus.mode_o, 0);
        repeat (3) step();
        chk("t5_alarm_stays_off", bus.alarm_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
